usb_packet_sender: RTL and testbench

- Serialises USB packets requested by the transaction FSMs (IN, OUT and similar) into a raw, pre-stuffing, pre-NRZI bit stream for the downstream bit-stuffer/NRZI/EOP stage.
- Builds the SYNC and PID fields for IN tokens, ACK, NAK and DATA0 packets.
- Adds the address and endpoint fields and CRC5 to tokens, and the payload and CRC16 to DATA0.
- Pulses `sent` after the last bit is accepted downstream.

---
 rtl/usb_packet_sender_if.sv | 11 +
 rtl/usb_packet_sender.sv | 203 ++++++++++++++++++++
 tb/tb_usb_packet_sender.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_packet_sender_if.sv
// Serial bit stream from the packet sender to the bit-stuffer/NRZI/EOP stage.
// A bit moves on any rising edge where out_valid && out_ready; out_bit/out_last hold while stalled.
interface usb_packet_sender_if;
  logic out_bit;
  logic out_valid;
  logic out_last;
  logic out_ready;

  modport master (output out_bit, output out_valid, output out_last, input out_ready);
  modport slave  (input out_bit, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/usb_packet_sender.sv
// USB packet serialiser: SYNC/PID for IN, ACK, NAK (+ DATA0 with payload/CRC16 when
// USB_SENDER_DATA_EN is defined), emitting a raw pre-stuffing bit stream.
module usb_packet_sender #(
  parameter logic [6:0] DEV_ADDR = 7'd5,
  parameter logic [3:0] DEV_ENDP = 4'd4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        send_IN,
  input  logic                        send_ACK,
  input  logic                        send_NAK,
  input  logic                        send_DATA0,
  input  logic [63:0]                 data_in,
  output logic                        busy,
  output logic                        sent,
  output logic [2:0]                  state_dbg,
  usb_packet_sender_if.master         tx
);

  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_DATA0 = 8'hC3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    PID   = 3'd2,
    TOKEN = 3'd3,
    CRC5  = 3'd4
`ifdef USB_SENDER_DATA_EN
    ,
    DATA  = 3'd5,
    CRC16 = 3'd6
`endif
  } state_t;

  state_t      state, state_nx;
  logic [6:0]  cnt, cnt_nx;
  logic [7:0]  pid, pid_nx;
  logic [4:0]  crc5;
  logic        accept, sent_nx, xfer, bit_o, last_o;
  logic [10:0] token_bits;

  assign token_bits = {DEV_ENDP, DEV_ADDR};
  assign xfer       = tx.out_valid && tx.out_ready;

  assign tx.out_valid = (state != IDLE);
  assign tx.out_bit   = bit_o;
  assign tx.out_last  = last_o;
  assign busy         = (state != IDLE);
  assign state_dbg    = state;

`ifdef USB_SENDER_DATA_EN
  logic [15:0] crc16;
  logic [63:0] payload;
`else
  logic unused_data;
  assign unused_data = ^{send_DATA0, data_in};
`endif

  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    return {c[3:0], 1'b0} ^ ((c[4] ^ b) ? 5'b00101 : 5'b00000);
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h8005 : 16'h0000);
  endfunction

  // Next-state, field counter and the serial bit; the counter only moves on transfers.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pid_nx   = pid;
    accept   = 1'b0;
    sent_nx  = 1'b0;
    bit_o    = 1'b0;
    last_o   = 1'b0;
    case (state)
      IDLE: begin
        if (send_IN) begin
          accept = 1'b1;
          pid_nx = PID_IN;
`ifdef USB_SENDER_DATA_EN
        end else if (send_DATA0) begin
          accept = 1'b1;
          pid_nx = PID_DATA0;
`endif
        end else if (send_ACK) begin
          accept = 1'b1;
          pid_nx = PID_ACK;
        end else if (send_NAK) begin
          accept = 1'b1;
          pid_nx = PID_NAK;
        end
        if (accept) begin
          state_nx = SYNC;
          cnt_nx   = 7'd0;
        end
      end
      SYNC: begin
        bit_o = (cnt == 7'd7);
        if (xfer) begin
          cnt_nx   = (cnt == 7'd7) ? 7'd0 : cnt + 7'd1;
          state_nx = (cnt == 7'd7) ? PID : SYNC;
        end
      end
      PID: begin
        bit_o  = pid[cnt[2:0]];
        last_o = (cnt == 7'd7) && (pid != PID_IN) && (pid != PID_DATA0);
        if (xfer) begin
          cnt_nx = (cnt == 7'd7) ? 7'd0 : cnt + 7'd1;
          if (cnt == 7'd7) begin
            if (pid == PID_IN) begin
              state_nx = TOKEN;
`ifdef USB_SENDER_DATA_EN
            end else if (pid == PID_DATA0) begin
              state_nx = DATA;
`endif
            end else begin
              state_nx = IDLE;
              sent_nx  = 1'b1;
            end
          end
        end
      end
      TOKEN: begin
        bit_o = token_bits[cnt[3:0]];
        if (xfer) begin
          cnt_nx   = (cnt == 7'd10) ? 7'd0 : cnt + 7'd1;
          state_nx = (cnt == 7'd10) ? CRC5 : TOKEN;
        end
      end
      CRC5: begin
        bit_o  = ~crc5[3'd4 - cnt[2:0]];
        last_o = (cnt == 7'd4);
        if (xfer) begin
          cnt_nx = cnt + 7'd1;
          if (cnt == 7'd4) begin
            state_nx = IDLE;
            sent_nx  = 1'b1;
          end
        end
      end
`ifdef USB_SENDER_DATA_EN
      DATA: begin
        bit_o = payload[cnt[5:0]];
        if (xfer) begin
          cnt_nx   = (cnt == 7'd63) ? 7'd0 : cnt + 7'd1;
          state_nx = (cnt == 7'd63) ? CRC16 : DATA;
        end
      end
      CRC16: begin
        bit_o  = ~crc16[4'd15 - cnt[3:0]];
        last_o = (cnt == 7'd15);
        if (xfer) begin
          cnt_nx = cnt + 7'd1;
          if (cnt == 7'd15) begin
            state_nx = IDLE;
            sent_nx  = 1'b1;
          end
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 7'd0;
      pid   <= 8'h00;
      sent  <= 1'b0;
      crc5  <= 5'h1F;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pid   <= pid_nx;
      sent  <= sent_nx;
      if (accept)
        crc5 <= 5'h1F;
      else if (xfer && state == TOKEN)
        crc5 <= crc5_step(crc5, bit_o);
    end
  end

`ifdef USB_SENDER_DATA_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc16   <= 16'hFFFF;
      payload <= 64'd0;
    end else if (accept) begin
      crc16 <= 16'hFFFF;
      if (pid_nx == PID_DATA0)
        payload <= data_in;
    end else if (xfer && state == DATA) begin
      crc16 <= crc16_step(crc16, bit_o);
    end
  end
`endif

endmodule

// File: tb/tb_usb_packet_sender.sv
// Directed bench for usb_packet_sender: one task per scenario, bit streams compared
// against hand-built expected queues.
module tb_usb_packet_sender;

  logic        clock = 1'b0;
  logic        reset;
  logic        send_IN, send_ACK, send_NAK, send_DATA0, send_IN5;
  logic [63:0] data_in;
  logic        busy, sent, busy5, sent5;
  logic [2:0]  state_dbg, state5;

  usb_packet_sender_if tx();
  usb_packet_sender_if tx5();

  usb_packet_sender #(.DEV_ADDR(7'd0), .DEV_ENDP(4'd0)) dut (
    .clock(clock), .reset(reset), .send_IN(send_IN), .send_ACK(send_ACK),
    .send_NAK(send_NAK), .send_DATA0(send_DATA0), .data_in(data_in),
    .busy(busy), .sent(sent), .state_dbg(state_dbg), .tx(tx)
  );

  usb_packet_sender dut5 (
    .clock(clock), .reset(reset), .send_IN(send_IN5), .send_ACK(1'b0),
    .send_NAK(1'b0), .send_DATA0(1'b0), .data_in(64'd0),
    .busy(busy5), .sent(sent5), .state_dbg(state5), .tx(tx5)
  );

  assign tx5.out_ready = 1'b1;

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // monitor state (written only by the monitor)
  int         cyc = 0, req_cyc = 0, busy_cyc = 0, sent_cnt = 0, sent_cyc = 0;
  int         last_cnt = 0, last_idx = -1, sent2_cnt = 0;
  logic [0:0] cap_q[$];
  logic [0:0] cap2_q[$];
  int         cyc_q[$];
  logic [0:0] exp_q[$];

  always @(negedge clock) begin
    cyc++;
    if (send_IN || send_ACK || send_NAK || send_DATA0) req_cyc = cyc;
    if (busy) busy_cyc++;
    if (sent) begin
      sent_cnt++;
      sent_cyc = cyc;
    end
    if (tx.out_valid && tx.out_ready) begin
      cap_q.push_back(tx.out_bit);
      cyc_q.push_back(cyc);
      if (tx.out_last) begin
        last_cnt++;
        last_idx = cap_q.size() - 1;
      end
    end
    if (tx5.out_valid && tx5.out_ready) cap2_q.push_back(tx5.out_bit);
    if (sent5) sent2_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic i, input logic a, input logic n, input logic d);
    send_IN = i; send_ACK = a; send_NAK = n; send_DATA0 = d;
    step();
    send_IN = 0; send_ACK = 0; send_NAK = 0; send_DATA0 = 0;
  endtask

  task automatic wait_sent(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget && sent_cnt < target; i++) step();
    ok = (sent_cnt >= target);
  endtask

  task automatic push_lsb(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endtask

  task automatic push_msb(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i]);
  endtask

  task automatic push_head(input logic [7:0] pid_byte);
    push_lsb(64'h80, 8);
    push_lsb({56'd0, pid_byte}, 8);
  endtask

  // index of first differing bit from cap_q[base] on, -1 when equal over exp_q
  function automatic int first_diff(input int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i >= cap_q.size()) return i;
      if (cap_q[base + i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [4:0] crc5_of(input logic [10:0] d);
    logic [4:0] c = 5'h1F;
    for (int i = 0; i < 11; i++) c = {c[3:0], 1'b0} ^ ((c[4] ^ d[i]) ? 5'h05 : 5'h00);
    return c;
  endfunction

  function automatic logic [15:0] crc16_of(input logic [63:0] d);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < 64; i++) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h8005 : 16'h0000);
    return c;
  endfunction

  task automatic test_reset();
    reset = 1; send_IN = 0; send_ACK = 0; send_NAK = 0; send_DATA0 = 0; send_IN5 = 0;
    data_in = 64'd0; tx.out_ready = 1;
    step(); step();
    reset = 0;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (sent !== 1'b0) begin bad++; $display("FAIL reset_sent got=%b want=0", sent); end
    total++; if (tx.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", tx.out_valid); end
    total++; if (tx.out_bit !== 1'b0) begin bad++; $display("FAIL reset_bit got=%b want=0", tx.out_bit); end
    total++; if (tx.out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", tx.out_last); end
    total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
  endtask

  task automatic test_ack();
    int base = cap_q.size(), s0 = sent_cnt, b0 = busy_cyc, l0 = last_cnt, d;
    bit ok;
    exp_q.delete(); push_head(8'hD2);
    pulse(0, 1, 0, 0);
    wait_sent(s0 + 1, 40, ok);
    repeat (3) step();
    total++; if (!ok) begin bad++; $display("FAIL ack_timeout got=no_sent want=sent"); end
    total++; if (cap_q.size() - base != 16) begin bad++; $display("FAIL ack_len got=%0d want=16", cap_q.size() - base); end
    d = first_diff(base);
    total++; if (d != -1) begin bad++; $display("FAIL ack_bits first_bad_index=%0d want=none", d); end
    total++; if (last_cnt - l0 != 1 || last_idx != base + 15) begin bad++; $display("FAIL ack_last got_idx=%0d want=%0d", last_idx - base, 15); end
    total++; if (sent_cnt - s0 != 1) begin bad++; $display("FAIL ack_sent_count got=%0d want=1", sent_cnt - s0); end
    if (cap_q.size() - base >= 16) begin
      total++; if (sent_cyc != cyc_q[base + 15] + 1) begin bad++; $display("FAIL ack_sent_time got=%0d want=%0d", sent_cyc, cyc_q[base + 15] + 1); end
    end
    total++; if (busy_cyc - b0 != 16) begin bad++; $display("FAIL ack_busy_cycles got=%0d want=16", busy_cyc - b0); end
  endtask

  task automatic test_in_zero();
    int base = cap_q.size(), s0 = sent_cnt, d;
    bit ok;
    exp_q.delete(); push_head(8'h69); push_lsb(64'd0, 11); push_msb(64'b01000, 5);
    pulse(1, 0, 0, 0);
    wait_sent(s0 + 1, 60, ok);
    repeat (3) step();
    total++; if (!ok) begin bad++; $display("FAIL in_timeout got=no_sent want=sent"); end
    total++; if (cap_q.size() - base != 32) begin bad++; $display("FAIL in_len got=%0d want=32", cap_q.size() - base); end
    d = first_diff(base);
    total++; if (d != -1) begin bad++; $display("FAIL in_bits first_bad_index=%0d want=none", d); end
    total++; if (sent_cyc - req_cyc != 33) begin bad++; $display("FAIL in_latency got=%0d want=33", sent_cyc - req_cyc); end
    total++; if (last_idx != base + 31) begin bad++; $display("FAIL in_last got_idx=%0d want=31", last_idx - base); end
  endtask

  task automatic test_in_addr();
    int s0 = sent2_cnt, base = cap2_q.size(), d = -1;
    logic [10:0] tok = {4'd4, 7'd5};
    exp_q.delete(); push_head(8'h69); push_lsb({53'd0, tok}, 11); push_msb({59'd0, ~crc5_of(tok)}, 5);
    send_IN5 = 1; step(); send_IN5 = 0;
    for (int i = 0; i < 60 && sent2_cnt == s0; i++) step();
    step();
    for (int i = 0; i < exp_q.size(); i++)
      if (d == -1 && (base + i >= cap2_q.size() || cap2_q[base + i] !== exp_q[i])) d = i;
    total++; if (cap2_q.size() - base != 32) begin bad++; $display("FAIL in5_len got=%0d want=32", cap2_q.size() - base); end
    total++; if (d != -1) begin bad++; $display("FAIL in5_bits first_bad_index=%0d want=none", d); end
    total++; if (sent2_cnt - s0 != 1) begin bad++; $display("FAIL in5_sent got=%0d want=1", sent2_cnt - s0); end
    total++; if (busy5 !== 1'b0 || state5 !== 3'd0) begin bad++; $display("FAIL in5_idle got=%b/%0d want=0/0", busy5, state5); end
  endtask

  task automatic test_nak_stall();
    int base = cap_q.size(), s0 = sent_cnt, d;
    bit held = 0;
    logic hb = 0, hl = 0;
    exp_q.delete(); push_head(8'h5A);
    pulse(0, 0, 1, 0);
    for (int i = 0; i < 200 && sent_cnt == s0; i++) begin
      if (held && tx.out_valid) begin
        total++;
        if (tx.out_bit !== hb || tx.out_last !== hl) begin
          bad++; $display("FAIL nak_stall_hold got=%b%b want=%b%b", tx.out_bit, tx.out_last, hb, hl);
        end
      end
      tx.out_ready = (i % 4 == 0) || (i % 4 == 3);
      held = tx.out_valid && !tx.out_ready;
      hb = tx.out_bit; hl = tx.out_last;
      step();
    end
    tx.out_ready = 1;
    repeat (3) step();
    total++; if (cap_q.size() - base != 16) begin bad++; $display("FAIL nak_xfers got=%0d want=16", cap_q.size() - base); end
    d = first_diff(base);
    total++; if (d != -1) begin bad++; $display("FAIL nak_bits first_bad_index=%0d want=none", d); end
    total++; if (sent_cnt - s0 != 1) begin bad++; $display("FAIL nak_sent_count got=%0d want=1", sent_cnt - s0); end
    if (cap_q.size() - base >= 16) begin
      total++; if (sent_cyc != cyc_q[base + 15] + 1) begin bad++; $display("FAIL nak_sent_time got=%0d want=%0d", sent_cyc, cyc_q[base + 15] + 1); end
    end
  endtask

  task automatic test_collision();
    int base = cap_q.size(), s0 = sent_cnt, d;
    bit ok;
    exp_q.delete(); push_head(8'h69); push_lsb(64'd0, 11); push_msb(64'b01000, 5);
    pulse(1, 0, 1, 0);
    repeat (5) step();
    pulse(0, 1, 0, 0);
    wait_sent(s0 + 1, 60, ok);
    repeat (20) step();
    total++; if (cap_q.size() - base != 32) begin bad++; $display("FAIL coll_len got=%0d want=32", cap_q.size() - base); end
    d = first_diff(base);
    total++; if (d != -1) begin bad++; $display("FAIL coll_bits first_bad_index=%0d want=none", d); end
    total++; if (sent_cnt - s0 != 1) begin bad++; $display("FAIL coll_sent_count got=%0d want=1", sent_cnt - s0); end
  endtask

  task automatic test_back_to_back();
    int base = cap_q.size(), s0 = sent_cnt, d;
    bit ok;
    exp_q.delete(); push_head(8'hD2); push_head(8'h5A);
    pulse(0, 1, 0, 0);
    for (int i = 0; i < 40 && sent !== 1'b1; i++) step();
    pulse(0, 0, 1, 0);
    wait_sent(s0 + 2, 40, ok);
    repeat (3) step();
    total++; if (cap_q.size() - base != 32) begin bad++; $display("FAIL b2b_len got=%0d want=32", cap_q.size() - base); end
    d = first_diff(base);
    total++; if (d != -1) begin bad++; $display("FAIL b2b_bits first_bad_index=%0d want=none", d); end
    if (cap_q.size() - base >= 17) begin
      total++; if (cyc_q[base + 16] != cyc_q[base + 15] + 2) begin bad++; $display("FAIL b2b_gap got=%0d want=2", cyc_q[base + 16] - cyc_q[base + 15]); end
    end
    total++; if (sent_cnt - s0 != 2) begin bad++; $display("FAIL b2b_sent_count got=%0d want=2", sent_cnt - s0); end
  endtask

  task automatic test_data0();
    int base = cap_q.size(), s0 = sent_cnt, b0 = busy_cyc;
`ifdef USB_SENDER_DATA_EN
    int d;
    bit ok;
    logic [63:0] pay = 64'h0706050403020100;
    exp_q.delete(); push_head(8'hC3); push_lsb(pay, 64); push_msb({48'd0, ~crc16_of(pay)}, 16);
    data_in = pay; send_DATA0 = 1; send_ACK = 1;
    step();
    send_DATA0 = 0; send_ACK = 0; data_in = 64'hFFFF_0000_AAAA_5555;
    wait_sent(s0 + 1, 150, ok);
    repeat (3) step();
    total++; if (cap_q.size() - base != 96) begin bad++; $display("FAIL data0_len got=%0d want=96", cap_q.size() - base); end
    d = first_diff(base);
    total++; if (d != -1) begin bad++; $display("FAIL data0_bits first_bad_index=%0d want=none", d); end
    total++; if (last_idx != base + 95) begin bad++; $display("FAIL data0_last got_idx=%0d want=95", last_idx - base); end
    total++; if (sent_cnt - s0 != 1) begin bad++; $display("FAIL data0_sent got=%0d want=1", sent_cnt - s0); end
`else
    data_in = 64'h0706050403020100;
    pulse(0, 0, 0, 1);
    repeat (20) step();
    total++; if (busy_cyc - b0 != 0) begin bad++; $display("FAIL data0_off_busy got=%0d want=0", busy_cyc - b0); end
    total++; if (cap_q.size() - base != 0) begin bad++; $display("FAIL data0_off_bits got=%0d want=0", cap_q.size() - base); end
    total++; if (sent_cnt - s0 != 0) begin bad++; $display("FAIL data0_off_sent got=%0d want=0", sent_cnt - s0); end
`endif
  endtask

  task automatic test_reset_mid();
    int base = cap_q.size(), s0 = sent_cnt, d;
    bit ok;
    pulse(1, 0, 0, 0);
    for (int i = 0; i < 50 && cap_q.size() - base < 10; i++) step();
    reset = 1;
    #1;
    total++; if (tx.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", tx.out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    step();
    reset = 0;
    repeat (40) step();
    total++; if (sent_cnt != s0) begin bad++; $display("FAIL rst_mid_sent got=%0d want=0", sent_cnt - s0); end
    total++; if (cap_q.size() - base != 10) begin bad++; $display("FAIL rst_mid_truncate got=%0d want=10", cap_q.size() - base); end
    base = cap_q.size(); s0 = sent_cnt;
    exp_q.delete(); push_head(8'h5A);
    pulse(0, 0, 1, 0);
    wait_sent(s0 + 1, 40, ok);
    repeat (3) step();
    total++; if (cap_q.size() - base != 16) begin bad++; $display("FAIL rst_nak_len got=%0d want=16", cap_q.size() - base); end
    d = first_diff(base);
    total++; if (d != -1) begin bad++; $display("FAIL rst_nak_bits first_bad_index=%0d want=none", d); end
    total++; if (sent_cnt - s0 != 1) begin bad++; $display("FAIL rst_nak_sent got=%0d want=1", sent_cnt - s0); end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_in_zero();
    test_in_addr();
    test_nak_stall();
    test_collision();
    test_back_to_back();
    test_data0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
